// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencing controller.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_CLK_ON    = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_DOM     = 5;
    localparam int DEF_NUM_PLL     = 3;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Single-bit flop-chain synchroniser for an asynchronous level input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Waits for PLL lock, enables clocks, then releases domain resets in ascending
// order with a programmable gap; any lock loss restarts the whole sequence.
//
// state      | meaning
// WAIT_LOCK  | all domains held in reset, clocks gated, waiting for lock_ok
// CLK_ON     | clocks running, first release delay counting down
// RELEASE    | at least one domain released, remaining ones still pending
// RUN        | all domains released, per-domain software resets honoured
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int NUM_PLL     = DEF_NUM_PLL,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               ref_clk_i,
    input  logic               glob_rst_i,
    input  logic [NUM_PLL-1:0] pll_locked_i,
    input  logic [NUM_PLL-1:0] pll_mask_i,
    input  logic [CNT_W-1:0]   release_dly_i,
    input  logic [NUM_DOM-1:0] clk_en_i,
    input  logic [NUM_DOM-1:0] sw_rst_i,
    output logic [NUM_DOM-1:0] rst_o,
    output logic [NUM_DOM-1:0] clk_en_o,
    output logic               seq_done_o,
    output logic [1:0]         state_o
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

    logic [NUM_PLL-1:0] sync_lock;
    logic               lock_ok;

    seq_state_e         state_q, state_d;
    logic [NUM_DOM-1:0] rst_q, rst_d;
    logic [NUM_DOM-1:0] clk_en_q, clk_en_d;
    logic               seq_done_q, seq_done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   dly_q, dly_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    for (genvar i = 0; i < NUM_PLL; i++) begin : g_lock_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i (ref_clk_i),
            .rst_i (glob_rst_i),
            .d_i   (pll_locked_i[i]),
            .q_o   (sync_lock[i])
        );
    end

    // The mask is deliberately not registered so that unmasking a dead PLL
    // takes effect on the very next edge.
    assign lock_ok = &(sync_lock | ~pll_mask_i);

    always_comb begin
        state_d    = state_q;
        rst_d      = rst_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        idx_d      = idx_q;
        clk_en_d   = '0;
        seq_done_d = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                rst_d = '1;
                cnt_d = '0;
                idx_d = '0;
                if (lock_ok) begin
                    state_d = ST_CLK_ON;
                    dly_d   = release_dly_i;
                    cnt_d   = release_dly_i;
                end
            end
            ST_CLK_ON, ST_RELEASE: begin
                if (cnt_q == '0) begin
                    rst_d[idx_q] = 1'b0;
                    cnt_d        = dly_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                rst_d = sw_rst_i;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        // Lock loss overrides any release or software reset in the same cycle.
        if (state_q != ST_WAIT_LOCK && !lock_ok) begin
            state_d = ST_WAIT_LOCK;
            rst_d   = '1;
            cnt_d   = '0;
            idx_d   = '0;
        end

        if (state_d != ST_WAIT_LOCK) begin
            clk_en_d = clk_en_i;
        end
        seq_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge ref_clk_i) begin
        if (glob_rst_i) begin
            state_q    <= ST_WAIT_LOCK;
            rst_q      <= '1;
            clk_en_q   <= '0;
            seq_done_q <= 1'b0;
            cnt_q      <= '0;
            dly_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            rst_q      <= rst_d;
            clk_en_q   <= clk_en_d;
            seq_done_q <= seq_done_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            idx_q      <= idx_d;
        end
    end

    assign rst_o      = rst_q;
    assign clk_en_o   = clk_en_q;
    assign seq_done_o = seq_done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench: expected reset-output changes are queued with their cycle
// when stimulus is applied, and checked whenever rst_o actually changes.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       glob_rst;
    logic [2:0] pll_locked;
    logic [2:0] pll_mask;
    logic [7:0] release_dly;
    logic [4:0] clk_en_in;
    logic [4:0] sw_rst;
    logic [4:0] rst_out;
    logic [4:0] clk_en_out;
    logic       seq_done;
    logic [1:0] state;

    rst_seq_ctrl dut (
        .ref_clk_i     (clk),
        .glob_rst_i    (glob_rst),
        .pll_locked_i  (pll_locked),
        .pll_mask_i    (pll_mask),
        .release_dly_i (release_dly),
        .clk_en_i      (clk_en_in),
        .sw_rst_i      (sw_rst),
        .rst_o         (rst_out),
        .clk_en_o      (clk_en_out),
        .seq_done_o    (seq_done),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] rst;
        logic       done;
        logic [1:0] st;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    logic [4:0] prev_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [4:0] r, input logic d, input logic [1:0] s);
        exp_t e;
        e.cyc = c; e.rst = r; e.done = d; e.st = s;
        sb_q.push_back(e);
    endtask

    // Ordered release of all five domains starting from CLK_ON entry cycle e_cyc.
    task automatic push_seq(input int e_cyc, input int dly);
        logic [4:0] r;
        for (int d = 0; d < 5; d++) begin
            r = 5'h1f;
            r = r << (d + 1);
            push(e_cyc + (d + 1) * (dly + 1), r, d == 4, (d == 4) ? 2'd3 : 2'd2);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (mon_en && rst_out !== prev_rst) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rst", rst_out, prev_rst);
            end else begin
                e = sb_q.pop_front();
                check("rst_cyc", cyc, e.cyc);
                check("rst_val", rst_out, e.rst);
                check("rst_done", seq_done, e.done);
                check("rst_state", state, e.st);
            end
        end
        prev_rst = rst_out;
    end

    initial begin
        int t0, e_cyc, c, r;
        glob_rst    = 1'b1;
        pll_locked  = 3'b000;
        pll_mask    = 3'b111;
        release_dly = 8'd3;
        clk_en_in   = 5'b10110;
        sw_rst      = 5'b00000;
        wait_cyc(3);
        check("rst_rst_o", rst_out, 5'h1f);
        check("rst_clk_en", clk_en_out, 5'h00);
        check("rst_done", seq_done, 1'b0);
        check("rst_state", state, 2'd0);
        mon_en   = 1;
        glob_rst = 1'b0;
        wait_cyc(2);
        check("wait_lock_hold", state, 2'd0);

        // dly=3 sequence; later dly change and sw_rst during RELEASE are ignored
        t0 = cyc;
        pll_locked = 3'b111;
        e_cyc = t0 + 3;
        push_seq(e_cyc, 3);
        wait_cyc(3);
        check("clk_on_entry", state, 2'd1);
        check("clk_en_entry", clk_en_out, 5'b10110);
        release_dly = 8'd7;
        clk_en_in   = 5'b01101;
        wait_cyc(1);
        check("clk_en_follow", clk_en_out, 5'b01101);
        check("still_reset", rst_out, 5'h1f);
        wait_cyc(4);
        sw_rst = 5'b00100;
        wait_cyc(5);
        sw_rst = 5'b00000;
        drain(100);
        check("run_state", state, 2'd3);
        check("run_done", seq_done, 1'b1);

        // software reset pulse in RUN
        c = cyc;
        sw_rst = 5'b00100;
        push(c + 1, 5'b00100, 1'b1, 2'd3);
        wait_cyc(5);
        sw_rst = 5'b00000;
        push(c + 6, 5'b00000, 1'b1, 2'd3);
        drain(20);

        // one-cycle PLL1 dropout, then relock with captured dly=7
        c = cyc;
        pll_locked = 3'b101;
        push(c + 3, 5'h1f, 1'b0, 2'd0);
        wait_cyc(1);
        pll_locked = 3'b111;
        push_seq(c + 4, 7);
        wait_cyc(2);
        check("loss_clk_en", clk_en_out, 5'h00);
        check("loss_state", state, 2'd0);
        drain(200);
        check("relock_done", seq_done, 1'b1);

        // PLL1 masked and dead: no effect until unmasked
        pll_mask   = 3'b101;
        pll_locked = 3'b101;
        wait_cyc(4);
        check("masked_run", state, 2'd3);
        c = cyc;
        pll_mask = 3'b111;
        push(c + 1, 5'h1f, 1'b0, 2'd0);
        wait_cyc(3);
        check("unmask_loss", state, 2'd0);
        c = cyc;
        release_dly = 8'd0;
        pll_mask    = 3'b101;
        push_seq(c + 1, 0);
        drain(50);
        check("masked_done", seq_done, 1'b1);

        // global reset mid-sequence, at the cycle domain 1 is released
        pll_mask    = 3'b111;
        pll_locked  = 3'b111;
        release_dly = 8'd2;
        c = cyc;
        glob_rst = 1'b1;
        push(c + 1, 5'h1f, 1'b0, 2'd0);
        wait_cyc(1);
        glob_rst = 1'b0;
        r = cyc;
        e_cyc = r + 3;
        push(e_cyc + 3, 5'b11110, 1'b0, 2'd2);
        push(e_cyc + 6, 5'b11100, 1'b0, 2'd2);
        wait_cyc(9);
        glob_rst = 1'b1;
        push(e_cyc + 7, 5'h1f, 1'b0, 2'd0);
        wait_cyc(1);
        check("grst_state", state, 2'd0);
        check("grst_clk_en", clk_en_out, 5'h00);
        check("grst_done", seq_done, 1'b0);
        drain(10);

        // maximum delay: 256-cycle spacing without wrap
        release_dly = 8'd255;
        glob_rst = 1'b0;
        r = cyc;
        push_seq(r + 3, 255);
        drain(1500);
        check("max_dly_done", seq_done, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
